// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, fixed 33-cycle latency
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign fixed up in DONE.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             I_clk,
   input  logic             I_rst,
   input  logic             I_valid,
   input  logic [2:0]       I_op,
   input  logic [WIDTH-1:0] I_data1,
   input  logic [WIDTH-1:0] I_data2,
   output logic             O_ready,
   output logic             O_valid,
   output logic [WIDTH-1:0] O_data
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [2:0]       op;
   logic             neg;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] b;

   logic             sign1, sign2, neg_in;
   logic [WIDTH-1:0] mag1, mag2;
   logic [WIDTH:0]   mul_sum, shifted, diff;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0] quo_s, rem_s, result;

   always_comb begin
      sign1  = I_data1[WIDTH-1] & (I_op == 3'd0 || I_op == 3'd1 || I_op == 3'd2 ||
                                   I_op == 3'd4 || I_op == 3'd6);
      sign2  = I_data2[WIDTH-1] & (I_op == 3'd0 || I_op == 3'd1 || I_op == 3'd4 ||
                                   I_op == 3'd6);
      // 0x80000000 negates to itself, which is the correct unsigned magnitude
      mag1   = sign1 ? -I_data1 : I_data1;
      mag2   = sign2 ? -I_data2 : I_data2;
      neg_in = (I_op == 3'd6) ? sign1 : (sign1 ^ sign2);
   end

   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
      shifted = {hi, lo[WIDTH-1]};
      diff    = shifted - {1'b0, b};
   end

   // Signed overflow (min / -1) yields min and 0 naturally; only divide-by-zero needs an override.
   always_comb begin
      prod_s = neg ? -{hi, lo} : {hi, lo};
      quo_s  = neg ? -lo : lo;
      rem_s  = neg ? -hi : hi;
      case (op)
         3'd0:          result = prod_s[WIDTH-1:0];
         3'd1, 3'd2,
         3'd3:          result = prod_s[2*WIDTH-1:WIDTH];
         3'd4, 3'd5:    result = div_zero ? {WIDTH{1'b1}} : quo_s;
         default:       result = rem_s;
      endcase
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state    <= IDLE;
         count    <= '0;
         op       <= '0;
         neg      <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         b        <= '0;
         O_ready  <= 1'b1;
         O_valid  <= 1'b0;
         O_data   <= '0;
      end else begin
         O_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (I_valid) begin
                  op       <= I_op;
                  neg      <= neg_in;
                  div_zero <= (I_data2 == '0);
                  hi       <= '0;
                  lo       <= mag1;
                  b        <= mag2;
                  count    <= '0;
                  O_ready  <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               if (op[2]) begin
                  if (!diff[WIDTH]) begin
                     hi <= diff[WIDTH-1:0];
                     lo <= {lo[WIDTH-2:0], 1'b1};
                  end else begin
                     hi <= shifted[WIDTH-1:0];
                     lo <= {lo[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  hi <= mul_sum[WIDTH:1];
                  lo <= {mul_sum[0], lo[WIDTH-1:1]};
               end
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1))
                  state <= DONE;
            end
            DONE: begin
               O_data  <= result;
               O_valid <= 1'b1;
               O_ready <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
